// File: rtl/cmlk_tg_pkg.sv
// Shared frame-type constants, sequencer state encoding and frame-order helper
// for the gate-pulse timing path.
package cmlk_tg_pkg;

  localparam logic [1:0] FRAME_BG = 2'b00;
  localparam logic [1:0] FRAME_A  = 2'b01;
  localparam logic [1:0] FRAME_B  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  // Next enabled frame after cur in cyclic BG -> A -> B order; a result <= cur
  // means the order wrapped, i.e. cur was the last enabled frame.
  function automatic logic [1:0] next_frame(input logic [2:0] mask, input logic [1:0] cur);
    logic [1:0] res;
    logic [1:0] idx;
    res = cur;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(cur) + k) % 3);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/laser_period_cnt.sv
// Free-running wrap counter: trig marks the cycle cnt equals period_max, cnt then wraps to 0.
// Registered count; clr has priority over en; no backpressure.
module laser_period_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period_max,
  output logic [CNT_W-1:0] cnt,
  output logic             trig
);

  assign trig = en && (cnt == period_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= trig ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cmlk_frame_sequencer.sv
// Laser period timing master stepping BG/A/B frames; start -> first frame one cycle later.
// Config is shadowed and only reloaded at sequence boundaries; no backpressure.
module cmlk_frame_sequencer
  import cmlk_tg_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PPF_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             run_mode,
  input  logic [CNT_W-1:0] laser_freq,
  input  logic [PPF_W-1:0] pulses_per_frame,
  input  logic [2:0]       frame_mask,
  input  logic [PPF_W-1:0] seq_count,
  output logic [CNT_W-1:0] laser_cnt_out,
  output logic             laser_trig,
  output logic [1:0]       frame_type,
  output logic             frame_start,
  output logic [PPF_W-1:0] seq_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [PPF_W:0] SEQ_ONE = 1;

  state_t           state, state_n;
  logic [CNT_W-1:0] freq_s, freq_s_n;
  logic [PPF_W-1:0] ppf_s, ppf_s_n, cnt_s, cnt_s_n;
  logic [PPF_W-1:0] pulse_cnt, pulse_cnt_n, seq_idx_n;
  logic [2:0]       mask_s, mask_s_n;
  logic             mode_s, mode_s_n;
  logic [1:0]       frame_type_n, nxt;
  logic             frame_start_n, done_n, cnt_clr, load_cfg, run_en;
  logic             frame_end, seq_end, fin;
  logic [PPF_W:0]   seq_inc;

  assign run_en = (state != ST_IDLE);
  assign busy   = run_en;

  laser_period_cnt #(.CNT_W(CNT_W)) u_laser_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (run_en),
    .clr        (cnt_clr),
    .period_max (freq_s),
    .cnt        (laser_cnt_out),
    .trig       (laser_trig)
  );

  always_comb begin
    state_n       = state;
    freq_s_n      = freq_s;
    ppf_s_n       = ppf_s;
    mask_s_n      = mask_s;
    mode_s_n      = mode_s;
    cnt_s_n       = cnt_s;
    frame_type_n  = frame_type;
    pulse_cnt_n   = pulse_cnt;
    seq_idx_n     = seq_idx;
    frame_start_n = 1'b0;
    done_n        = 1'b0;
    cnt_clr       = 1'b0;
    load_cfg      = 1'b0;
    nxt           = next_frame(mask_s, frame_type);
    frame_end     = laser_trig && ((pulse_cnt + PPF_W'(1)) == ppf_s);
    seq_end       = frame_end && (nxt <= frame_type);
    seq_inc       = {1'b0, seq_idx} + SEQ_ONE;
    fin           = seq_end && mode_s && (seq_inc == {1'b0, cnt_s});

    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start && !stop && frame_mask != 3'b000) begin
          state_n       = ST_RUN;
          load_cfg      = 1'b1;
          frame_type_n  = next_frame(frame_mask, FRAME_B);
          frame_start_n = 1'b1;
          pulse_cnt_n   = '0;
          seq_idx_n     = '0;
        end
      end
      default: begin
        if (laser_trig) pulse_cnt_n = pulse_cnt + PPF_W'(1);
        if (state == ST_RUN && stop) state_n = ST_STOPPING;
        if (frame_end) begin
          pulse_cnt_n = '0;
          if (seq_end && !(&seq_idx)) seq_idx_n = seq_idx + PPF_W'(1);
          // A boundary with an all-zero new mask has nothing to run, so it ends like a stop.
          if (state == ST_STOPPING || stop || fin || (seq_end && frame_mask == 3'b000)) begin
            state_n      = ST_IDLE;
            done_n       = 1'b1;
            frame_type_n = FRAME_BG;
            cnt_clr      = 1'b1;
          end else begin
            frame_start_n = 1'b1;
            if (seq_end) begin
              load_cfg     = 1'b1;
              frame_type_n = next_frame(frame_mask, FRAME_B);
            end else begin
              frame_type_n = nxt;
            end
          end
        end
      end
    endcase

    if (load_cfg) begin
      freq_s_n = (laser_freq == '0) ? CNT_W'(1) : laser_freq;
      ppf_s_n  = (pulses_per_frame == '0) ? PPF_W'(1) : pulses_per_frame;
      mask_s_n = frame_mask;
      mode_s_n = run_mode;
      cnt_s_n  = (seq_count == '0) ? PPF_W'(1) : seq_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      freq_s      <= '0;
      ppf_s       <= '0;
      mask_s      <= '0;
      mode_s      <= 1'b0;
      cnt_s       <= '0;
      frame_type  <= FRAME_BG;
      pulse_cnt   <= '0;
      seq_idx     <= '0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      freq_s      <= freq_s_n;
      ppf_s       <= ppf_s_n;
      mask_s      <= mask_s_n;
      mode_s      <= mode_s_n;
      cnt_s       <= cnt_s_n;
      frame_type  <= frame_type_n;
      pulse_cnt   <= pulse_cnt_n;
      seq_idx     <= seq_idx_n;
      frame_start <= frame_start_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_cmlk_frame_sequencer.sv
// Self-checking bench for cmlk_frame_sequencer: vector table, directed corner sequences
// and randomized traffic against a frame-timeline reference model.
module tb_cmlk_frame_sequencer;

  localparam int CNT_W = 32;
  localparam int PPF_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             run_mode = 1'b0;
  logic [CNT_W-1:0] laser_freq = '0;
  logic [PPF_W-1:0] pulses_per_frame = '0;
  logic [2:0]       frame_mask = '0;
  logic [PPF_W-1:0] seq_count = '0;
  logic [CNT_W-1:0] laser_cnt_out;
  logic             laser_trig;
  logic [1:0]       frame_type;
  logic             frame_start;
  logic [PPF_W-1:0] seq_idx;
  logic             busy;
  logic             done;

  cmlk_frame_sequencer #(.CNT_W(CNT_W), .PPF_W(PPF_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .stop             (stop),
    .run_mode         (run_mode),
    .laser_freq       (laser_freq),
    .pulses_per_frame (pulses_per_frame),
    .frame_mask       (frame_mask),
    .seq_count        (seq_count),
    .laser_cnt_out    (laser_cnt_out),
    .laser_trig       (laser_trig),
    .frame_type       (frame_type),
    .frame_start      (frame_start),
    .seq_idx          (seq_idx),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a frame is a run of P*ppf cycles indexed by m_t.
  bit m_busy, m_stop, m_done;
  int m_t, m_P, m_ppf, m_mask, m_mode, m_cnt, m_ft, m_seq;

  typedef struct {
    int freq; int ppf; int mask; int cnt;
    int exp_len; int exp_fs; int exp_seq;
  } vec_t;
  vec_t vecs[6];

  int  k, fs, done_k, trig_k;
  bit  saw_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 25) $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input int mask, input int from);
    for (int i = from; i < 3; i++) if (mask[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_stop = 0; m_done = 0;
    m_t = 0; m_P = 1; m_ppf = 1; m_mask = 0; m_mode = 0; m_cnt = 1; m_ft = 0; m_seq = 0;
  endtask

  task automatic model_load();
    m_P    = ((laser_freq == 0) ? 1 : int'(laser_freq)) + 1;
    m_ppf  = (pulses_per_frame == 0) ? 1 : int'(pulses_per_frame);
    m_mask = int'(frame_mask);
    m_mode = int'(run_mode);
    m_cnt  = (seq_count == 0) ? 1 : int'(seq_count);
  endtask

  task automatic model_adv();
    int nx, old;
    bit bnd, fin;
    m_done = 0;
    if (!m_busy) begin
      if (start && !stop && frame_mask != 0) begin
        model_load();
        m_busy = 1; m_stop = 0; m_t = 0; m_seq = 0;
        m_ft = lowest(m_mask, 0);
      end
    end else begin
      if (stop) m_stop = 1;
      if (m_t == m_P * m_ppf - 1) begin
        nx  = lowest(m_mask, m_ft + 1);
        bnd = (nx < 0);
        old = m_seq;
        if (bnd && m_seq < 65535) m_seq++;
        fin = bnd && (m_mode != 0) && (old + 1 == m_cnt);
        if (bnd && !m_stop && !fin) model_load();
        if (m_stop || fin || (bnd && m_mask == 0)) begin
          m_busy = 0; m_stop = 0; m_done = 1; m_t = 0; m_ft = 0;
        end else begin
          m_t  = 0;
          m_ft = bnd ? lowest(m_mask, 0) : nx;
        end
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_busy);
    chk("laser_cnt", laser_cnt_out, m_busy ? m_t % m_P : 0);
    chk("laser_trig", laser_trig, m_busy && (m_t % m_P == m_P - 1));
    chk("frame_type", frame_type, m_busy ? m_ft : 0);
    chk("frame_start", frame_start, m_busy && m_t == 0);
    chk("seq_idx", seq_idx, m_seq);
    chk("done", done, m_done);
  endtask

  task automatic cyc();
    model_adv();
    @(posedge clk); #1;
    check_outputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4, 2, 7, 1, 30, 3, 1};
    vecs[1] = '{2, 1, 6, 2, 12, 4, 2};
    vecs[2] = '{0, 3, 1, 2, 12, 2, 2};
    vecs[3] = '{3, 0, 4, 1,  4, 1, 1};
    vecs[4] = '{1, 2, 5, 0,  8, 2, 1};
    vecs[5] = '{0, 0, 2, 3,  6, 3, 3};

    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs();
    rst_n = 1'b1;
    cyc(); cyc();

    // Finite runs from the vector table.
    for (int i = 0; i < 6; i++) begin
      laser_freq       = vecs[i].freq;
      pulses_per_frame = PPF_W'(vecs[i].ppf);
      frame_mask       = 3'(vecs[i].mask);
      seq_count        = PPF_W'(vecs[i].cnt);
      run_mode         = 1'b1;
      start = 1'b1; cyc(); start = 1'b0;
      k = 1; fs = frame_start ? 1 : 0; done_k = -1;
      for (int j = 0; j < 200 && done_k < 0; j++) begin
        cyc(); k++;
        if (frame_start) fs++;
        if (done) done_k = k;
      end
      chk("vec_len", done_k - 1, vecs[i].exp_len);
      chk("vec_frame_starts", fs, vecs[i].exp_fs);
      chk("vec_seq_idx", seq_idx, vecs[i].exp_seq);
      chk("vec_busy_after", busy, 0);
      cyc(); cyc();
    end

    // Continuous A/B alternation every 3 cycles.
    laser_freq = 2; pulses_per_frame = 1; frame_mask = 3'b110; run_mode = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int kk = 1; kk <= 18; kk++) begin
      chk("cont_ft", frame_type, (((kk - 1) / 3) % 2) != 0 ? 2 : 1);
      chk("cont_seq", seq_idx, (kk - 1) / 6);
      cyc();
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    repeat (8) cyc();

    // Mid-sequence laser_freq change only takes effect at the boundary.
    laser_freq = 4; pulses_per_frame = 2; frame_mask = 3'b111; run_mode = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    trig_k = -1;
    for (int kk = 1; kk <= 60; kk++) begin
      if (kk == 12) laser_freq = 9;
      if (kk == 25) chk("cfg_hold_trig", laser_trig, 1);
      if (kk > 30 && laser_trig && trig_k < 0) trig_k = kk;
      cyc();
    end
    chk("cfg_new_period", trig_k, 40);
    stop = 1'b1; cyc(); stop = 1'b0;
    repeat (25) cyc();

    // Stop in the 3rd cycle of frame A: A completes, B never entered.
    laser_freq = 4; pulses_per_frame = 2; frame_mask = 3'b111; run_mode = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    done_k = -1; saw_b = 1'b0;
    for (int kk = 1; kk <= 40; kk++) begin
      if (frame_type == 2'b10) saw_b = 1'b1;
      if (done && done_k < 0) done_k = kk;
      stop = (kk == 13);
      cyc();
    end
    stop = 1'b0;
    chk("stop_done_cycle", done_k, 21);
    chk("stop_no_frame_b", saw_b, 0);

    // Empty mask start is ignored.
    frame_mask = 3'b000; laser_freq = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int kk = 0; kk < 5; kk++) begin
      chk("mask0_busy", busy, 0);
      cyc();
    end

    // Async reset mid-frame, then restart.
    laser_freq = 4; pulses_per_frame = 2; frame_mask = 3'b110; run_mode = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (6) cyc();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_outputs();
    repeat (3) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("rst_restart_ft", frame_type, 1);
    chk("rst_restart_seq", seq_idx, 0);
    repeat (5) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    repeat (12) cyc();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) begin
        laser_freq       = $urandom_range(0, 3);
        pulses_per_frame = PPF_W'($urandom_range(0, 3));
        frame_mask       = 3'($urandom_range(0, 7));
        run_mode         = 1'($urandom_range(0, 1));
        seq_count        = PPF_W'($urandom_range(0, 3));
      end
      cyc();
    end
    start = 1'b0; stop = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmlk_frame_sequencer.md
Name: cmlk_frame_sequencer

Overview:
Timing master for the gate pulse path. It runs the free-running laser period counter and steps the frame type through the background, A and B frames.
- Laser counter output feeds laser_cnt_in of the gate pulse generator.
- Frame type output feeds its frame_type input; each change restarts that block's delay-step cycle counter.
- Configuration is shadowed, so software writes only take effect at sequence boundaries.

Parameters:
CNT_W, 32, laser counter / laser_freq width
PPF_W, 16, pulses-per-frame and sequence-count width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  1-cycle pulse; begin sequencing (ignored unless IDLE)
stop  in  1  1-cycle pulse; graceful stop at end of current frame
run_mode  in  1  0 = continuous, 1 = finite (seq_count sequences)
laser_freq  in  CNT_W  laser period minus 1, in clk cycles
pulses_per_frame  in  PPF_W  laser periods per frame
frame_mask  in  3  bit0 = BG, bit1 = A, bit2 = B frame enabled
seq_count  in  PPF_W  sequences to run in finite mode
laser_cnt_out  out  CNT_W  period counter
laser_trig  out  1  high in the cycle laser_cnt_out equals the shadowed laser_freq
frame_type  out  2  00 = BG, 01 = A, 10 = B
frame_start  out  1  1-cycle pulse on first cycle of every frame
seq_idx  out  PPF_W  completed-sequence count
busy  out  1  state is not IDLE
done  out  1  1-cycle pulse when finite run or stop completes

Behaviour:
- Reset values: state IDLE; all outputs 0; all shadows 0.
- States:
  - IDLE: laser_cnt_out held at 0, frame_type = 00, laser_trig = 0.
    - start with frame_mask != 0 -> RUN.
    - start with frame_mask == 0 is ignored and stays in IDLE.
  - RUN: sequencing active.
  - STOPPING: same counting as RUN, but no new frame is entered.
- Shadowing: on accepted start, latch laser_freq_s, ppf_s, mask_s, mode_s, cnt_s. Re-latch the same set at every sequence boundary. Zero values of laser_freq and ppf are clamped to 1.
- Start latency: start seen in cycle N -> cycle N+1 has:
  - busy = 1, laser_cnt_out = 0, frame_start = 1;
  - frame_type = lowest enabled frame in order BG, A, B;
  - seq_idx = 0.
- Laser counter:
  - Increments by 1 each cycle.
  - In the cycle it equals laser_freq_s: laser_trig = 1 and the next value is 0.
  - Period is laser_freq_s + 1 cycles.
- Pulse counter: increments on laser_trig. A frame ends on the laser_trig that completes ppf_s periods.
- At frame end, the next enabled frame (cyclic BG -> A -> B) takes effect on the same cycle laser_cnt_out wraps to 0, with frame_start = 1.
- Sequence boundary = end of the last enabled frame in the mask.
  - seq_idx increments there, saturating at all-ones.
  - Shadows reload there.
- Finite mode: at the boundary where seq_idx + 1 == cnt_s (cnt_s of 0 clamped to 1):
  - go to IDLE, pulse done, frame_type = 00, counter cleared.
- stop in RUN -> STOPPING. At the end of the current frame -> IDLE with a done pulse.
- stop in IDLE or STOPPING is ignored.
- Simultaneous events:
  - stop and the frame end in the same cycle: go to IDLE directly with done.
  - start and stop together in IDLE: start is ignored.
- Single-enabled mask: every frame end is a sequence boundary, and frame_start still pulses on each one.
- Async reset mid-run: immediately forces IDLE and zero outputs. No done pulse is generated.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package cmlk_tg_pkg holds:
  - FRAME_BG / FRAME_A / FRAME_B 2-bit constants;
  - state encoding;
  - next_frame(mask, cur) function.
- One sub-module, laser_period_cnt: wrap counter with laser_trig, plus enable and synchronous clear.

Test Plan:
- Reset then start: laser_freq = 4, ppf = 2, mask = 111, run_mode = 1, seq_count = 1 -> frame_type 00, 01, 10 for 10 cycles each.
  - laser_trig every 5th cycle.
  - 3 frame_start pulses; done 30 cycles after the first frame_start; busy then 0.
- Continuous, mask = 110, ppf = 1, laser_freq = 2 -> frame_type alternates 01, 10 every 3 cycles; seq_idx increments every 6 cycles.
- Config change mid-sequence: laser_freq 4 -> 9 written during frame A -> period stays 5 until the sequence boundary, then becomes 10.
- stop pulsed during the 3rd cycle of a 10-cycle frame A -> frame completes, then IDLE with done; frame B is never entered.
- frame_mask = 000 with start -> busy stays 0; no outputs toggle. laser_freq = 0 -> period 2 cycles (clamped).
- rst_n asserted mid-frame for 1 cycle -> outputs 0 asynchronously; no done pulse. A new start then restarts at the first enabled frame with seq_idx = 0.
